// File: rtl/charge_mode_ctrl_if.sv
// Control and status bundle between the start/stop logic, the charge sequencer
// and the averaging filter that consumes the regulation window.
interface charge_mode_ctrl_if;
  logic        start;
  logic        stop;
  logic        tick;
  logic [11:0] v_ave;
  logic [11:0] i_ave;
  logic [11:0] win_max;
  logic [11:0] win_min;
  logic        fb_sel;
  logic        pwm_en;
  logic [2:0]  state_o;
  logic        done;
  logic        fault;

  modport master (
    output start, stop, tick, v_ave, i_ave,
    input  win_max, win_min, fb_sel, pwm_en, state_o, done, fault
  );

  modport slave (
    input  start, stop, tick, v_ave, i_ave,
    output win_max, win_min, fb_sel, pwm_en, state_o, done, fault
  );
endinterface

// File: rtl/charge_mode_ctrl.sv
// CC->CV battery charge sequencer: soft-start ramp, CC/CV regulation windows,
// handover/termination dwell qualification, over-voltage and timeout trips.
module charge_mode_ctrl #(
  parameter logic [11:0] I_CC     = 12'd1200,
  parameter logic [11:0] I_WIN    = 12'd40,
  parameter logic [11:0] V_CV     = 12'd2450,
  parameter logic [11:0] V_WIN    = 12'd50,
  parameter logic [11:0] I_TERM   = 12'd120,
  parameter logic [11:0] V_OVP    = 12'd2700,
  parameter logic [11:0] SS_START = 12'd64,
  parameter logic [11:0] SS_STEP  = 12'd16,
  parameter logic [3:0]  DWELL    = 4'd8,
  parameter logic [19:0] TIMEOUT  = 20'd600000
) (
  input logic               clk_1M,
  input logic               rst_n,
  charge_mode_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SOFT  = 3'd1,
    CC    = 3'd2,
    CV    = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t      state_reg;
  logic [11:0] target_reg;
  logic [3:0]  dwell_reg;
  logic [19:0] tcnt_reg;
  logic [11:0] win_max_reg;
  logic [11:0] win_min_reg;
  logic        fb_sel_reg;
  logic        pwm_en_reg;
  logic        done_reg;
  logic        fault_reg;

  logic [12:0] ramp_sum;
  logic        ramp_done;
  logic [4:0]  dwell_inc;
  logic        dwell_full;
  logic [19:0] tcnt_inc;
  logic        active;
  logic        ovp_hit;
  logic        tmo_hit;
  logic        cc_qual;
  logic        cv_qual;

  // Window edges saturate instead of wrapping so the filter never sees an
  // inverted or aliased band near the ends of the ADC range.
  function automatic logic [11:0] win_hi(input logic [11:0] center, input logic [11:0] half);
    logic [12:0] sum;
    sum = {1'b0, center} + {1'b0, half};
    return sum[12] ? 12'hFFF : sum[11:0];
  endfunction

  function automatic logic [11:0] win_lo(input logic [11:0] center, input logic [11:0] half);
    logic [12:0] diff;
    diff = {1'b0, center} - {1'b0, half};
    return diff[12] ? 12'd0 : diff[11:0];
  endfunction

  always_comb begin
    ramp_sum   = {1'b0, target_reg} + {1'b0, SS_STEP};
    ramp_done  = (ramp_sum >= {1'b0, I_CC});
    dwell_inc  = {1'b0, dwell_reg} + 5'd1;
    dwell_full = (dwell_inc >= {1'b0, DWELL});
    tcnt_inc   = tcnt_reg + 20'd1;
    active     = (state_reg == SOFT) || (state_reg == CC) || (state_reg == CV);
    ovp_hit    = active && bus.tick && (bus.v_ave >= V_OVP);
    tmo_hit    = active && bus.tick && (tcnt_inc >= TIMEOUT);
    cc_qual    = (bus.v_ave >= V_CV);
    cv_qual    = (bus.i_ave <= I_TERM);
  end

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      target_reg  <= 12'd0;
      dwell_reg   <= 4'd0;
      tcnt_reg    <= 20'd0;
      win_max_reg <= 12'd0;
      win_min_reg <= 12'd0;
      fb_sel_reg  <= 1'b1;
      pwm_en_reg  <= 1'b0;
      done_reg    <= 1'b0;
      fault_reg   <= 1'b0;
    end else if (bus.stop) begin
      state_reg   <= IDLE;
      win_max_reg <= 12'd0;
      win_min_reg <= 12'd0;
      fb_sel_reg  <= 1'b1;
      pwm_en_reg  <= 1'b0;
      done_reg    <= 1'b0;
      fault_reg   <= 1'b0;
    end else if (ovp_hit || tmo_hit) begin
      state_reg  <= FAULT;
      pwm_en_reg <= 1'b0;
      done_reg   <= 1'b0;
      fault_reg  <= 1'b1;
    end else begin
      if (active && bus.tick) begin
        tcnt_reg <= tcnt_inc;
      end
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            state_reg   <= SOFT;
            target_reg  <= SS_START;
            dwell_reg   <= 4'd0;
            tcnt_reg    <= 20'd0;
            win_max_reg <= win_hi(SS_START, I_WIN);
            win_min_reg <= win_lo(SS_START, I_WIN);
            fb_sel_reg  <= 1'b1;
            pwm_en_reg  <= 1'b1;
            done_reg    <= 1'b0;
          end
        end
        SOFT: begin
          if (bus.tick) begin
            if (ramp_done) begin
              state_reg   <= CC;
              target_reg  <= I_CC;
              win_max_reg <= win_hi(I_CC, I_WIN);
              win_min_reg <= win_lo(I_CC, I_WIN);
            end else begin
              target_reg  <= ramp_sum[11:0];
              win_max_reg <= win_hi(ramp_sum[11:0], I_WIN);
              win_min_reg <= win_lo(ramp_sum[11:0], I_WIN);
            end
          end
        end
        CC: begin
          // Handover needs DWELL consecutive ticks at or above the CV target.
          if (bus.tick) begin
            if (!cc_qual) begin
              dwell_reg <= 4'd0;
            end else if (dwell_full) begin
              state_reg   <= CV;
              dwell_reg   <= 4'd0;
              fb_sel_reg  <= 1'b0;
              win_max_reg <= win_hi(V_CV, V_WIN);
              win_min_reg <= win_lo(V_CV, V_WIN);
            end else begin
              dwell_reg <= dwell_inc[3:0];
            end
          end
        end
        CV: begin
          if (bus.tick) begin
            if (!cv_qual) begin
              dwell_reg <= 4'd0;
            end else if (dwell_full) begin
              state_reg  <= DONE;
              dwell_reg  <= 4'd0;
              pwm_en_reg <= 1'b0;
              done_reg   <= 1'b1;
            end else begin
              dwell_reg <= dwell_inc[3:0];
            end
          end
        end
        FAULT: begin
          state_reg <= FAULT;
        end
        default: begin
          state_reg   <= IDLE;
          win_max_reg <= 12'd0;
          win_min_reg <= 12'd0;
          fb_sel_reg  <= 1'b1;
          pwm_en_reg  <= 1'b0;
          done_reg    <= 1'b0;
          fault_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.win_max = win_max_reg;
  assign bus.win_min = win_min_reg;
  assign bus.fb_sel  = fb_sel_reg;
  assign bus.pwm_en  = pwm_en_reg;
  assign bus.state_o = state_reg;
  assign bus.done    = done_reg;
  assign bus.fault   = fault_reg;

endmodule

// File: doc/charge_mode_ctrl.md
# charge_mode_ctrl

Sequences the CC→CV battery charge profile around the buck averaging/PWM-adjust loop. It drives the filter's regulation window (max/min thresholds) and the feedback-source select, and ramps the current target at soft start. It detects the CC→CV handover and CV termination, and trips on over-voltage or timeout. It sits between the top-level start/stop control and the averaging filter, and runs in the same 1 MHz domain.

## Interface
Parameters:
- I_CC, 12'd1200: CC current target (ADC codes)
- I_WIN, 12'd40: half-width of the current window
- V_CV, 12'd2450: CV voltage target
- V_WIN, 12'd50: half-width of the voltage window
- I_TERM, 12'd120: CV termination current
- V_OVP, 12'd2700: over-voltage trip level
- SS_START, 12'd64: initial soft-start current target
- SS_STEP, 12'd16: soft-start increment per tick
- DWELL, 4'd8: consecutive qualifying ticks required for CC→CV and CV→DONE
- TIMEOUT, 20'd600000: maximum active ticks before fault

Ports:
- clk_1M, input, 1: system clock. The block uses one clock only.
- rst_n, input, 1: reset, asynchronous, active-low
- start, input, 1: level. Begins a charge from IDLE or DONE.
- stop, input, 1: level. Forces IDLE from any state.
- tick, input, 1: one-cycle pulse, asserted when v_ave/i_ave hold a fresh average
- v_ave, input, 12: averaged battery voltage
- i_ave, input, 12: averaged charge current
- win_max, output, 12: window upper bound, to the filter's max input
- win_min, output, 12: window lower bound, to the filter's min input
- fb_sel, output, 1: feedback source. 1 = current (i_ave path), 0 = voltage.
- pwm_en, output, 1: gate for the PWM output stage
- state_o, output, 3: current state encoding
- done, output, 1: high in DONE
- fault, output, 1: high in FAULT

## Operation
- States and encodings: IDLE=0, SOFT=1, CC=2, CV=3, DONE=4, FAULT=5. Unused encodings return to IDLE on the next clock.
- Transition priority, applied every clock: stop > OVP > timeout > normal transition.
- IDLE
  - pwm_en=0, fb_sel=1, windows=0.
  - start=1 → SOFT, with target=SS_START, dwell counter cleared, tick counter cleared.
  - Does not wait for tick.
- SOFT
  - pwm_en=1, fb_sel=1.
  - On each tick, target += SS_STEP.
  - If the new target ≥ I_CC, target clamps to I_CC and the state moves to CC.
- CC
  - Window = I_CC ± I_WIN.
  - On each tick: if v_ave ≥ V_CV, dwell++; otherwise dwell=0.
  - When dwell reaches DWELL → CV, with dwell cleared.
- CV
  - fb_sel=0. Window = V_CV ± V_WIN.
  - On each tick: if i_ave ≤ I_TERM, dwell++; otherwise dwell=0.
  - When dwell reaches DWELL → DONE.
- DONE
  - pwm_en=0, done=1, windows hold their last value.
  - start=1 → SOFT (restart).
- FAULT
  - pwm_en=0, fault=1. Sticky: leaves only via stop (→IDLE) or rst_n.
- OVP: in SOFT, CC or CV, a tick with v_ave ≥ V_OVP → FAULT on that edge.
- Timeout: a 20-bit counter increments on every tick in SOFT, CC and CV. Reaching TIMEOUT → FAULT. The counter clears on entry to SOFT.
- Window arithmetic:
  - Compute at 13 bits.
  - win_max = min(target + half, 4095).
  - win_min = max(target − half, 0), with no wrap.
  - SOFT uses target ± I_WIN.
- Both start and stop high: stop wins, and the state stays IDLE.

## Timing
- Reset values: state IDLE, win_max=0, win_min=0, fb_sel=1, pwm_en=0, done=0, fault=0, state_o=0, all counters 0.
- Registering: all outputs are registered and reflect the new state on the same edge as the transition. Latency from input to output is 1 clock.
- Sampling: v_ave and i_ave are sampled only on cycles with tick=1. Values on other cycles are ignored.
- tick while stop=1: not counted.
- rst_n deasserted mid-charge: everything returns immediately (asynchronously) to reset values. Recovery to SOFT needs start after reset release.
- start held high through DONE: re-enters SOFT on the next clock.

## Test plan
- Soft-start ramp:
  - Stimulus: reset, then start=1, with tick every 6 clocks.
  - Required: target follows 64, 80, …; win_max/win_min = target ± 40.
  - After 71 ticks the target reaches 1200 (clamped) and the state is CC, with window 1240/1160.
- CC→CV handover:
  - Stimulus: in CC, v_ave=2450 for 7 ticks, then 2449 for one tick, then 2450 for 8 ticks.
  - Required: CV is entered only on the 8th tick of the second run, with fb_sel=0 and window 2500/2400.
- Termination:
  - Stimulus: in CV, i_ave=120 for 8 ticks.
  - Required: DONE, done=1, pwm_en=0.
  - Then start=1 → SOFT, and the window restarts at 104/24.
- OVP and sticky fault:
  - Stimulus: in CC, a tick with v_ave=2700.
  - Required: FAULT on that edge, fault=1, pwm_en=0.
  - start is ignored in FAULT; stop → IDLE.
- Saturation:
  - Stimulus: I_WIN=100 with SS_START=64.
  - Required: win_min=0, not a wrapped value. With I_CC=4080 and I_WIN=40, win_max=4095.
- Priority and reset:
  - Stimulus: a tick with v_ave=2800 and stop=1 → IDLE, not FAULT.
  - Stimulus: rst_n pulsed low mid-CV → all outputs at reset values before the next clock edge.
